// File: rtl/ahb_master_arbiter_if.sv
`default_nettype none
// ahb_master_arbiter_if: the two AHB-Lite master ports and the shared slave port around the arbiter.
// The slave modport is the arbiter's view of the bus; master is the surrounding environment's view.
interface ahb_master_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] m0_HADDR;
    logic [1:0]        m0_HTRANS;
    logic              m0_HWRITE;
    logic [2:0]        m0_HSIZE;
    logic [DATA_W-1:0] m0_HWDATA;
    logic [DATA_W-1:0] m0_HRDATA;
    logic              m0_HREADY;
    logic              m0_HRESP;

    logic [ADDR_W-1:0] m1_HADDR;
    logic [1:0]        m1_HTRANS;
    logic              m1_HWRITE;
    logic [2:0]        m1_HSIZE;
    logic [DATA_W-1:0] m1_HWDATA;
    logic [DATA_W-1:0] m1_HRDATA;
    logic              m1_HREADY;
    logic              m1_HRESP;

    logic              s_HSEL;
    logic [ADDR_W-1:0] s_HADDR;
    logic [1:0]        s_HTRANS;
    logic              s_HWRITE;
    logic [2:0]        s_HSIZE;
    logic [DATA_W-1:0] s_HWDATA;
    logic              s_HREADY;
    logic [DATA_W-1:0] s_HRDATA;
    logic              s_HREADYOUT;
    logic              s_HRESP;

    modport slave (
        input  m0_HADDR, m0_HTRANS, m0_HWRITE, m0_HSIZE, m0_HWDATA,
        output m0_HRDATA, m0_HREADY, m0_HRESP,
        input  m1_HADDR, m1_HTRANS, m1_HWRITE, m1_HSIZE, m1_HWDATA,
        output m1_HRDATA, m1_HREADY, m1_HRESP,
        output s_HSEL, s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HWDATA, s_HREADY,
        input  s_HRDATA, s_HREADYOUT, s_HRESP
    );

    modport master (
        output m0_HADDR, m0_HTRANS, m0_HWRITE, m0_HSIZE, m0_HWDATA,
        input  m0_HRDATA, m0_HREADY, m0_HRESP,
        output m1_HADDR, m1_HTRANS, m1_HWRITE, m1_HSIZE, m1_HWDATA,
        input  m1_HRDATA, m1_HREADY, m1_HRESP,
        input  s_HSEL, s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HWDATA, s_HREADY,
        output s_HRDATA, s_HREADYOUT, s_HRESP
    );
endinterface
`default_nettype wire

// File: rtl/ahb_master_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// ahb_master_arbiter: two-master (instruction/data) to one-slave AHB-Lite arbiter.
// Contested address phases are parked per master and replayed when the slave frees.
// Revision: 1.0
//------------------------------------------------------------------------------
module ahb_master_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahb_master_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    owner_t            r_owner;
    owner_t            w_owner_nxt;
    logic              r_last_grant;
    logic [1:0]        r_pend_valid;
    logic [ADDR_W-1:0] r_pend_addr [2];
    logic [1:0]        r_pend_write;
    logic [2:0]        r_pend_size [2];
    logic [ADDR_W-1:0] r_hold_addr;
    logic              r_hold_write;
    logic [2:0]        r_hold_size;

    logic [ADDR_W-1:0] w_live_addr [2];
    logic [1:0]        w_live_write;
    logic [2:0]        w_live_size [2];
    logic [1:0]        w_live_req;
    logic [1:0]        w_ready;
    logic [1:0]        w_new;
    logic [1:0]        w_cand;
    logic              w_issue;
    logic              w_win;
    logic [ADDR_W-1:0] w_iss_addr;
    logic              w_iss_write;
    logic [2:0]        w_iss_size;
    logic [DATA_W-1:0] w_wdata;
    logic              w_own0;
    logic              w_own1;

    assign w_live_addr[0]  = bus.m0_HADDR;
    assign w_live_addr[1]  = bus.m1_HADDR;
    assign w_live_size[0]  = bus.m0_HSIZE;
    assign w_live_size[1]  = bus.m1_HSIZE;
    assign w_live_write    = {bus.m1_HWRITE, bus.m0_HWRITE};
    assign w_live_req      = {bus.m1_HTRANS[1], bus.m0_HTRANS[1]};

    // A parked master is always stalled; an owning master sees the slave's ready.
    assign w_ready[0] = !HRESETn || (!r_pend_valid[0] && ((r_owner != OWN_M0) || bus.s_HREADYOUT));
    assign w_ready[1] = !HRESETn || (!r_pend_valid[1] && ((r_owner != OWN_M1) || bus.s_HREADYOUT));

    assign w_new   = w_live_req & w_ready;
    assign w_cand  = r_pend_valid | w_new;
    assign w_issue = HRESETn && bus.s_HREADYOUT && (w_cand != 2'b00);
    assign w_win   = (&w_cand) ? ((ARB_MODE == 0) ? 1'b1 : ~r_last_grant) : w_cand[1];

    always_comb begin
        w_iss_addr  = w_live_addr[w_win];
        w_iss_write = w_live_write[w_win];
        w_iss_size  = w_live_size[w_win];
        if (r_pend_valid[w_win]) begin
            w_iss_addr  = r_pend_addr[w_win];
            w_iss_write = r_pend_write[w_win];
            w_iss_size  = r_pend_size[w_win];
        end
    end

    always_comb begin
        w_owner_nxt = r_owner;
        if (w_issue) begin
            w_owner_nxt = w_win ? OWN_M1 : OWN_M0;
        end else if (bus.s_HREADYOUT) begin
            w_owner_nxt = OWN_NONE;
        end
    end

    always_comb begin
        w_wdata = '0;
        case (r_owner)
            OWN_M0:  w_wdata = bus.m0_HWDATA;
            OWN_M1:  w_wdata = bus.m1_HWDATA;
            default: w_wdata = '0;
        endcase
    end

    assign w_own0 = HRESETn && (r_owner == OWN_M0);
    assign w_own1 = HRESETn && (r_owner == OWN_M1);

    assign bus.s_HSEL    = w_issue;
    assign bus.s_HTRANS  = w_issue ? TRANS_NONSEQ : TRANS_IDLE;
    assign bus.s_HADDR   = w_issue ? w_iss_addr  : r_hold_addr;
    assign bus.s_HWRITE  = w_issue ? w_iss_write : r_hold_write;
    assign bus.s_HSIZE   = w_issue ? w_iss_size  : r_hold_size;
    assign bus.s_HWDATA  = w_wdata;
    assign bus.s_HREADY  = bus.s_HREADYOUT;

    assign bus.m0_HRDATA = w_own0 ? bus.s_HRDATA : '0;
    assign bus.m0_HRESP  = w_own0 & bus.s_HRESP;
    assign bus.m0_HREADY = w_ready[0];
    assign bus.m1_HRDATA = w_own1 ? bus.s_HRDATA : '0;
    assign bus.m1_HRESP  = w_own1 & bus.s_HRESP;
    assign bus.m1_HREADY = w_ready[1];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_owner      <= OWN_NONE;
            r_last_grant <= 1'b0;
            r_pend_valid <= '0;
            r_hold_addr  <= '0;
            r_hold_write <= 1'b0;
            r_hold_size  <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            if (w_issue) begin
                r_last_grant <= w_win;
                r_hold_addr  <= w_iss_addr;
                r_hold_write <= w_iss_write;
                r_hold_size  <= w_iss_size;
            end
            for (int i = 0; i < 2; i++) begin
                if (w_issue && (w_win == i[0])) begin
                    r_pend_valid[i] <= 1'b0;
                end else if (w_new[i]) begin
                    r_pend_valid[i] <= 1'b1;
                end
            end
        end
    end

    // Payload is only consumed while its valid bit is set, so it needs no reset.
    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (w_new[i] && !(w_issue && (w_win == i[0]))) begin
                r_pend_addr[i]  <= w_live_addr[i];
                r_pend_write[i] <= w_live_write[i];
                r_pend_size[i]  <= w_live_size[i];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
`default_nettype none
// tb_ahb_master_arbiter: directed vector table plus a reset-mid-operation sequence
// for the instruction/data AHB-Lite arbiter, in both arbitration modes.
module tb_ahb_master_arbiter;
    localparam logic [1:0]  TI = 2'b00;
    localparam logic [1:0]  TB = 2'b01;
    localparam logic [1:0]  TN = 2'b10;
    localparam logic [1:0]  TS = 2'b11;
    localparam logic [31:0] D0 = 32'h0D0D_0D0D;
    localparam int          NVEC = 27;

    typedef struct packed {
        logic        rstn;
        logic        mode;
        logic [1:0]  t0;
        logic [31:0] a0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic        w1;
        logic [31:0] d1;
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
        logic        e_sel;
        logic        ca;
        logic [31:0] e_addr;
        logic        e_write;
        logic [2:0]  e_size;
        logic        cw;
        logic [31:0] e_wdata;
        logic        e_rdy0;
        logic        e_rdy1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_resp0;
        logic        e_resp1;
    } vec_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [1:0]  t0, t1;
    logic [31:0] a0, a1, d1, rdata;
    logic        w1, rdy, resp;
    logic        cur_mode;
    int          checks = 0;
    int          errors = 0;
    vec_t        tv [NVEC];

    always #5 HCLK = ~HCLK;

    ahb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    ahb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    ahb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0.slave));
    ahb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1.slave));

    assign bus0.m0_HADDR = a0;     assign bus1.m0_HADDR = a0;
    assign bus0.m0_HTRANS = t0;    assign bus1.m0_HTRANS = t0;
    assign bus0.m0_HWRITE = 1'b0;  assign bus1.m0_HWRITE = 1'b0;
    assign bus0.m0_HSIZE = 3'd2;   assign bus1.m0_HSIZE = 3'd2;
    assign bus0.m0_HWDATA = D0;    assign bus1.m0_HWDATA = D0;
    assign bus0.m1_HADDR = a1;     assign bus1.m1_HADDR = a1;
    assign bus0.m1_HTRANS = t1;    assign bus1.m1_HTRANS = t1;
    assign bus0.m1_HWRITE = w1;    assign bus1.m1_HWRITE = w1;
    assign bus0.m1_HSIZE = 3'd1;   assign bus1.m1_HSIZE = 3'd1;
    assign bus0.m1_HWDATA = d1;    assign bus1.m1_HWDATA = d1;
    assign bus0.s_HRDATA = rdata;  assign bus1.s_HRDATA = rdata;
    assign bus0.s_HREADYOUT = rdy; assign bus1.s_HREADYOUT = rdy;
    assign bus0.s_HRESP = resp;    assign bus1.s_HRESP = resp;

    logic        mx_sel, mx_write, mx_hready, mx_rdy0, mx_rdy1, mx_resp0, mx_resp1;
    logic [1:0]  mx_trans;
    logic [2:0]  mx_size;
    logic [31:0] mx_addr, mx_wdata, mx_rd0, mx_rd1;

    always_comb begin
        mx_sel = bus0.s_HSEL;     mx_trans = bus0.s_HTRANS;   mx_addr = bus0.s_HADDR;
        mx_write = bus0.s_HWRITE; mx_size = bus0.s_HSIZE;     mx_wdata = bus0.s_HWDATA;
        mx_hready = bus0.s_HREADY;
        mx_rdy0 = bus0.m0_HREADY; mx_rd0 = bus0.m0_HRDATA;    mx_resp0 = bus0.m0_HRESP;
        mx_rdy1 = bus0.m1_HREADY; mx_rd1 = bus0.m1_HRDATA;    mx_resp1 = bus0.m1_HRESP;
        if (cur_mode) begin
            mx_sel = bus1.s_HSEL;     mx_trans = bus1.s_HTRANS;   mx_addr = bus1.s_HADDR;
            mx_write = bus1.s_HWRITE; mx_size = bus1.s_HSIZE;     mx_wdata = bus1.s_HWDATA;
            mx_hready = bus1.s_HREADY;
            mx_rdy0 = bus1.m0_HREADY; mx_rd0 = bus1.m0_HRDATA;    mx_resp0 = bus1.m0_HRESP;
            mx_rdy1 = bus1.m1_HREADY; mx_rd1 = bus1.m1_HRDATA;    mx_resp1 = bus1.m1_HRESP;
        end
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b want %b", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        HRESETn = v.rstn; cur_mode = v.mode;
        t0 = v.t0; a0 = v.a0; t1 = v.t1; a1 = v.a1; w1 = v.w1; d1 = v.d1;
        rdy = v.rdy; resp = v.resp; rdata = v.rdata;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chkb("s_HSEL", i, mx_sel, v.e_sel);
        chk("s_HTRANS", i, 32'(mx_trans), v.e_sel ? 32'd2 : 32'd0);
        if (v.ca) begin
            chk("s_HADDR", i, mx_addr, v.e_addr);
            chkb("s_HWRITE", i, mx_write, v.e_write);
            chk("s_HSIZE", i, 32'(mx_size), 32'(v.e_size));
        end
        if (v.cw) chk("s_HWDATA", i, mx_wdata, v.e_wdata);
        chkb("s_HREADY", i, mx_hready, v.rdy);
        chkb("m0_HREADY", i, mx_rdy0, v.e_rdy0);
        chkb("m1_HREADY", i, mx_rdy1, v.e_rdy1);
        chk("m0_HRDATA", i, mx_rd0, v.e_rd0);
        chk("m1_HRDATA", i, mx_rd1, v.e_rd1);
        chkb("m0_HRESP", i, mx_resp0, v.e_resp0);
        chkb("m1_HRESP", i, mx_resp1, v.e_resp1);
    endtask

    task automatic idle_inputs();
        t0 = TI; a0 = '0; t1 = TI; a1 = '0; w1 = 1'b0; d1 = '0;
        rdy = 1'b1; resp = 1'b0; rdata = '0;
    endtask

    initial begin
        // rstn mode | t0 a0 | t1 a1 w1 d1 | rdy resp rdata || sel ca addr write size | cw wdata | rdy0 rdy1 rd0 rd1 resp0 resp1
        tv[0]  = '{'0,'0, TI,32'h0,        TI,32'h0,'0,32'h0,          '1,'0,32'hDEADBEEF, '0,'0,32'h0,'0,3'd0,        '0,32'h0,         '1,'1,32'h0,32'h0,'0,'0};
        tv[1]  = '{'0,'0, TN,32'h1C000800, TN,32'h1C010000,'1,32'h0,   '1,'0,32'hDEADBEEF, '0,'0,32'h0,'0,3'd0,        '0,32'h0,         '1,'1,32'h0,32'h0,'0,'0};
        tv[2]  = '{'1,'0, TN,32'h1C000800, TI,32'h0,'0,32'h0,          '1,'0,32'h0,        '1,'1,32'h1C000800,'0,3'd2, '0,32'h0,         '1,'1,32'h0,32'h0,'0,'0};
        tv[3]  = '{'1,'0, TI,32'h0,        TI,32'h0,'0,32'h0,          '1,'0,32'hA5A50001, '0,'1,32'h1C000800,'0,3'd2, '1,D0,            '1,'1,32'hA5A50001,32'h0,'0,'0};
        tv[4]  = '{'1,'0, TN,32'h1C000804, TN,32'h1C010010,'1,32'h0,   '1,'0,32'h0,        '1,'1,32'h1C010010,'1,3'd1, '0,32'h0,         '1,'1,32'h0,32'h0,'0,'0};
        tv[5]  = '{'1,'0, TI,32'h0,        TI,32'h0,'0,32'hCAFEF00D,   '1,'0,32'h11111111, '1,'1,32'h1C000804,'0,3'd2, '1,32'hCAFEF00D,  '0,'1,32'h0,32'h11111111,'0,'0};
        tv[6]  = '{'1,'0, TI,32'h0,        TI,32'h0,'0,32'h0,          '1,'0,32'h22220002, '0,'1,32'h1C000804,'0,3'd2, '1,D0,            '1,'1,32'h22220002,32'h0,'0,'0};
        tv[7]  = '{'1,'0, TI,32'h0,        TN,32'h1C010020,'1,32'h0,   '1,'0,32'h0,        '1,'1,32'h1C010020,'1,3'd1, '0,32'h0,         '1,'1,32'h0,32'h0,'0,'0};
        tv[8]  = '{'1,'0, TN,32'h1C000900, TI,32'h0,'0,32'h12345678,   '0,'0,32'h33333333, '0,'1,32'h1C010020,'1,3'd1, '1,32'h12345678,  '1,'0,32'h0,32'h33333333,'0,'0};
        tv[9]  = '{'1,'0, TI,32'h0,        TI,32'h0,'0,32'h12345678,   '0,'0,32'h33333333, '0,'1,32'h1C010020,'1,3'd1, '1,32'h12345678,  '0,'0,32'h0,32'h33333333,'0,'0};
        tv[10] = tv[9];
        tv[11] = '{'1,'0, TI,32'h0,        TI,32'h0,'0,32'h12345678,   '1,'0,32'h44444444, '1,'1,32'h1C000900,'0,3'd2, '1,32'h12345678,  '0,'1,32'h0,32'h44444444,'0,'0};
        tv[12] = '{'1,'0, TI,32'h0,        TI,32'h0,'0,32'h0,          '1,'0,32'h55555555, '0,'1,32'h1C000900,'0,3'd2, '1,D0,            '1,'1,32'h55555555,32'h0,'0,'0};
        tv[13] = '{'1,'0, TI,32'h0,        TB,32'h1C010030,'0,32'h0,   '1,'0,32'h0,        '0,'1,32'h1C000900,'0,3'd2, '0,32'h0,         '1,'1,32'h0,32'h0,'0,'0};
        tv[14] = '{'1,'0, TI,32'h0,        TI,32'h1C010030,'0,32'h0,   '1,'0,32'h0,        '0,'1,32'h1C000900,'0,3'd2, '0,32'h0,         '1,'1,32'h0,32'h0,'0,'0};
        tv[15] = '{'1,'0, TS,32'h1C000808, TI,32'h0,'0,32'h0,          '1,'0,32'h0,        '1,'1,32'h1C000808,'0,3'd2, '0,32'h0,         '1,'1,32'h0,32'h0,'0,'0};
        tv[16] = '{'1,'0, TI,32'h0,        TN,32'h1C010030,'0,32'h0,   '1,'0,32'h66666666, '1,'1,32'h1C010030,'0,3'd1, '1,D0,            '1,'1,32'h66666666,32'h0,'0,'0};
        tv[17] = '{'1,'0, TI,32'h0,        TI,32'h0,'0,32'h0,          '0,'1,32'h0,        '0,'1,32'h1C010030,'0,3'd1, '0,32'h0,         '1,'0,32'h0,32'h0,'0,'1};
        tv[18] = '{'1,'0, TI,32'h0,        TI,32'h0,'0,32'h0,          '1,'1,32'h0,        '0,'1,32'h1C010030,'0,3'd1, '0,32'h0,         '1,'1,32'h0,32'h0,'0,'1};
        tv[19] = '{'1,'0, TI,32'h0,        TI,32'h0,'0,32'h0,          '1,'0,32'h77777777, '0,'1,32'h1C010030,'0,3'd1, '0,32'h0,         '1,'1,32'h0,32'h0,'0,'0};
        // Alternating policy: four back-to-back conflicts grant M1, M0, M1, M0.
        tv[20] = '{'0,'1, TI,32'h0,        TI,32'h0,'0,32'h0,          '1,'0,32'h0,        '0,'0,32'h0,'0,3'd0,        '0,32'h0,         '1,'1,32'h0,32'h0,'0,'0};
        tv[21] = '{'1,'1, TN,32'h1C000A10, TN,32'h1C010040,'1,32'h0,   '1,'0,32'h0,        '1,'1,32'h1C010040,'1,3'd1, '0,32'h0,         '1,'1,32'h0,32'h0,'0,'0};
        tv[22] = '{'1,'1, TI,32'h0,        TN,32'h1C010044,'1,32'hAAAA0001, '1,'0,32'h0,   '1,'1,32'h1C000A10,'0,3'd2, '1,32'hAAAA0001,  '0,'1,32'h0,32'h0,'0,'0};
        tv[23] = '{'1,'1, TN,32'h1C000A14, TI,32'h0,'0,32'h0,          '1,'0,32'h88888888, '1,'1,32'h1C010044,'1,3'd1, '1,D0,            '1,'0,32'h88888888,32'h0,'0,'0};
        tv[24] = '{'1,'1, TI,32'h0,        TN,32'h1C010048,'1,32'hAAAA0002, '1,'0,32'h0,   '1,'1,32'h1C000A14,'0,3'd2, '1,32'hAAAA0002,  '0,'1,32'h0,32'h0,'0,'0};
        tv[25] = '{'1,'1, TI,32'h0,        TI,32'h0,'0,32'h0,          '1,'0,32'h99999999, '1,'1,32'h1C010048,'1,3'd1, '1,D0,            '1,'0,32'h99999999,32'h0,'0,'0};
        tv[26] = '{'1,'1, TI,32'h0,        TI,32'h0,'0,32'hAAAA0003,   '1,'0,32'h0,        '0,'1,32'h1C010048,'1,3'd1, '1,32'hAAAA0003,  '1,'1,32'h0,32'h0,'0,'0};

        HRESETn = 1'b0; cur_mode = 1'b0;
        idle_inputs();

        for (int i = 0; i < NVEC; i++) begin
            @(negedge HCLK);
            apply(tv[i]);
            #1;
            check_vec(i, tv[i]);
        end

        // Reset while M0 is parked and M1 owns a stalled data phase.
        @(negedge HCLK);
        cur_mode = 1'b0; HRESETn = 1'b0; idle_inputs();
        @(negedge HCLK);
        HRESETn = 1'b1; t1 = TN; a1 = 32'h1C010050; w1 = 1'b1;
        #1;
        chkb("rst_seq m1 issue", 100, mx_sel, 1'b1);
        chk("rst_seq m1 addr", 100, mx_addr, 32'h1C010050);
        @(negedge HCLK);
        t1 = TI; d1 = 32'hBBBB0001; t0 = TN; a0 = 32'h1C000B00; rdy = 1'b0;
        #1;
        chkb("rst_seq busy no issue", 101, mx_sel, 1'b0);
        chkb("rst_seq m1 stalled", 101, mx_rdy1, 1'b0);
        chkb("rst_seq m0 accepted", 101, mx_rdy0, 1'b1);
        @(negedge HCLK);
        t0 = TI;
        #1;
        chkb("rst_seq m0 parked", 102, mx_rdy0, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b0; rdata = 32'hCCCC0001;
        #1;
        chk("rst_seq forced trans", 103, 32'(mx_trans), 32'd0);
        chkb("rst_seq forced m0 ready", 103, mx_rdy0, 1'b1);
        chkb("rst_seq forced m1 ready", 103, mx_rdy1, 1'b1);
        chk("rst_seq forced m1 rdata", 103, mx_rd1, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1; rdy = 1'b1;
        #1;
        chkb("rst_seq no replay", 104, mx_sel, 1'b0);
        chkb("rst_seq m0 ready", 104, mx_rdy0, 1'b1);
        chkb("rst_seq m1 ready", 104, mx_rdy1, 1'b1);
        @(negedge HCLK);
        t0 = TN; a0 = 32'h1C000A00;
        #1;
        chkb("rst_seq direct issue", 105, mx_sel, 1'b1);
        chk("rst_seq direct addr", 105, mx_addr, 32'h1C000A00);
        @(negedge HCLK);
        idle_inputs();
        @(negedge HCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Two-master to one-slave AHB-Lite arbiter that lets the RI5CY core's instruction port (ins_*) and data port (dat_*) share one AHB-Lite slave, typically a unified memory or cache. It sits between the core wrapper and the slave-side decode/mux stage. Uncontested transfers pass through with zero added latency. A contested transfer's address phase is captured in a per-master pending register and replayed to the slave later, with the losing master stalled via its HREADY.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ARB_MODE, 0, conflict policy: 0 = fixed priority (M1 data over M0 instruction); 1 = alternate, loser of the last conflict wins the next
- HCLK  in  1  clock; all state on rising edge
- HRESETn  in  1  reset, synchronous, active-low
- m0_HADDR / m1_HADDR  in  ADDR_W  master address
- m0_HTRANS / m1_HTRANS  in  2  transfer type
- m0_HWRITE / m1_HWRITE  in  1  write flag
- m0_HSIZE / m1_HSIZE  in  3  transfer size
- m0_HWDATA / m1_HWDATA  in  DATA_W  write data
- m0_HRDATA / m1_HRDATA  out  DATA_W  read data
- m0_HREADY / m1_HREADY  out  1  data-phase completion to master
- m0_HRESP / m1_HRESP  out  1  response to master
- s_HSEL  out  1  slave select
- s_HADDR  out  ADDR_W  slave address
- s_HTRANS  out  2  slave transfer type
- s_HWRITE  out  1  slave write flag
- s_HSIZE  out  3  slave transfer size
- s_HWDATA  out  DATA_W  slave write data
- s_HREADY  out  1  bus HREADY to slave; equals s_HREADYOUT
- s_HRDATA  in  DATA_W  slave read data
- s_HREADYOUT  in  1  slave ready
- s_HRESP  in  1  slave response

## Operation
- Valid request: HTRANS[1]=1 (NONSEQ/SEQ). IDLE and BUSY are ignored. HBURST is not used; each beat is arbitrated independently and issued to the slave as NONSEQ (2'b10).
- New request from Mi: HTRANS[1] & mi_HREADY. Candidate i = pend_valid_i | new request from Mi. A master with pend_valid set always has HREADY=0, so it cannot present a new request at the same time.
- Slave free: s_HREADYOUT=1.
- Issue rules:
  - When the slave is free and there is at least one candidate, issue exactly one winner combinationally.
  - s_HSEL=1, s_HTRANS=10.
  - s_HADDR, s_HWRITE, s_HSIZE come from the pending register if pend_valid, otherwise from the live master inputs.
  - owner <= winner at the clock edge.
- Capture rule: a new request that is not issued in its cycle (lost arbitration, or slave busy) is latched into pend_i (addr, write, size), and pend_valid_i <= 1.
- pend_valid_i clears on the edge at which pend_i is issued.
- Arbitration when both are candidates:
  - ARB_MODE=0: M1 wins.
  - ARB_MODE=1: the master not equal to last_grant wins; last_grant updates on every issue.
- Data phase (owner != NONE):
  - s_HWDATA = owner's live HWDATA. The master holds it stable because its HREADY stays low until completion.
  - owner HRDATA = s_HRDATA, HREADY = s_HREADYOUT, HRESP = s_HRESP.
  - Non-owner: HRDATA=0, HRESP=0.
  - owner clears to NONE on an edge with s_HREADYOUT=1 if nothing is issued that cycle.
- mi_HREADY:
  - 0 if pend_valid_i.
  - Otherwise s_HREADYOUT if owner==i.
  - Otherwise 1.
- No issue: s_HSEL=0, s_HTRANS=00; s_HADDR/s_HWRITE/s_HSIZE hold their last values.

## Timing
- Reset values (HRESETn low at an edge): pend_valid_0/1=0, owner=NONE, last_grant=M0.
- While HRESETn is low, outputs are forced: s_HTRANS=00, s_HSEL=0, m*_HREADY=1, m*_HRDATA=0, m*_HRESP=0.
- Uncontested latency: 0 cycles added; the slave sees the address in the same cycle as the master.
- Contested loser stall: its HREADY stays low for the winner's data-phase cycles plus its own data-phase cycles.
- Back-to-back: a pending request issues in the same cycle the previous data phase completes (s_HREADYOUT=1), giving full pipelining with no idle bubble.
- Simultaneous events:
  - Pending M0 plus new M1, ARB_MODE=0: M1 wins and is captured/issued per the rules; M0 waits.
  - Both pending: the policy decides. Starvation is impossible in ARB_MODE=1. In ARB_MODE=0, M0 starves only under continuous M1 traffic; this is accepted.
- Reset mid-operation: pending requests and the owner are discarded at the reset edge, with no replay after reset.
- The slave error response is passed through verbatim over its two cycles to the owner.

## Test plan
1. Single transfer: M0 NONSEQ read 0x1C000800, slave zero-wait returns 0xA5A50001 → s_HADDR=0x1C000800 in the same cycle; m0_HRDATA=0xA5A50001 with m0_HREADY=1 on the next cycle; M1 outputs HREADY=1, HRDATA=0.
2. Conflict, ARB_MODE=0: same cycle, M0 reads 0x1C000804 and M1 writes 0x1C010010 with data 0xCAFEF00D.
   - Cycle 0: M1 issued.
   - Cycle 1: s_HWDATA=0xCAFEF00D; M0 pending issued with s_HADDR=0x1C000804; m0_HREADY=0.
   - Cycle 2: m0 read completes.
3. ARB_MODE=1, four consecutive conflict cycles → grant order M1, M0, M1, M0, no bubbles.
4. Wait states: during M1's data phase, s_HREADYOUT is held low 3 cycles while M0 presents 0x1C000900 → M0 is captured and s_HTRANS=00 while waiting; M0 issues on the cycle s_HREADYOUT returns 1; m1_HREADY tracks s_HREADYOUT.
5. Reset while M0 is pending and M1 owns a data phase → after the reset edge, s_HTRANS=00, both HREADY=1; the first post-reset M0 request at 0x1C000A00 is issued directly.
6. Transfer-type handling:
   - M1 drives BUSY then IDLE → no slave transfer.
   - M0 SEQ at 0x1C000808 → slave sees NONSEQ at 0x1C000808.
   - Slave 2-cycle HRESP=1 on an M1 transfer → mirrored on m1_HRESP only.
